spi_exe_unit_gen: RTL

- Parametrised SPI-slave execution unit, the successor of the fixed 8-bit SPI execution unit.
- Within one chip-select frame it receives an opcode and two W-bit operands on MOSI, executes one ALU operation, then shifts the result and four flags out on MISO.
- Adds configurable operand width, frame-abort detection, an illegal-opcode error, and done/busy status for the local system.

---
 rtl/spi_exe_pkg.sv | 33 +++
 rtl/alu_gen.sv | 61 ++++++
 rtl/spi_exe_unit_gen.sv | 130 +++++++++++++
 3 files changed

// File: rtl/spi_exe_pkg.sv
// Shared definitions for the parametrised SPI execution unit.
//   op_e    : ALU opcodes 0..7; any wider code >= 8 is illegal
//   state_e : frame FSM states
//   *_IDX   : bit positions of the four flags in the flags vector
package spi_exe_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_XOR  = 3'd4,
    OP_SHL  = 3'd5,
    OP_SHR  = 3'd6,
    OP_PASS = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    READY     = 3'd0,
    LOAD_OP   = 3'd1,
    LOAD_A    = 3'd2,
    LOAD_B    = 3'd3,
    EXEC      = 3'd4,
    SHIFT_OUT = 3'd5,
    DONE      = 3'd6
  } state_e;

  localparam int unsigned PF_IDX = 3;
  localparam int unsigned ZF_IDX = 2;
  localparam int unsigned SF_IDX = 1;
  localparam int unsigned OF_IDX = 0;

endpackage

// File: rtl/alu_gen.sv
// Combinational W-bit ALU for the SPI execution unit.
//   argA, argB : operands
//   oper       : OPW-bit opcode; codes >= 8 are illegal
//   result     : W-bit result (0 for an illegal opcode)
//   flags      : {PF, ZF, SF, OF} at PF_IDX..OF_IDX
//   illegal    : high when oper >= 8
module alu_gen
  import spi_exe_pkg::*;
#(
  parameter int W   = 8,
  parameter int OPW = 4
) (
  input  logic [W-1:0]   argA,
  input  logic [W-1:0]   argB,
  input  logic [OPW-1:0] oper,
  output logic [W-1:0]   result,
  output logic [3:0]     flags,
  output logic           illegal
);

  localparam int SHW = $clog2(W);

  logic [SHW-1:0] shamt;
  logic           ovf;

  assign shamt = argB[SHW-1:0];

  always_comb begin
    illegal = (32'(oper) > 32'd7);
    result  = '0;
    ovf     = 1'b0;
    case (op_e'(oper[2:0]))
      OP_ADD: begin
        result = argA + argB;
        ovf    = (argA[W-1] == argB[W-1]) && (result[W-1] != argA[W-1]);
      end
      OP_SUB: begin
        result = argA - argB;
        ovf    = (argA[W-1] != argB[W-1]) && (result[W-1] != argA[W-1]);
      end
      OP_AND:  result = argA & argB;
      OP_OR:   result = argA | argB;
      OP_XOR:  result = argA ^ argB;
      OP_SHL:  result = argA << shamt;
      OP_SHR:  result = argA >> shamt;
      OP_PASS: result = argA;
      default: result = '0;
    endcase
    // A zero result yields the required illegal flag pattern {1,1,0,0}.
    if (illegal) begin
      result = '0;
      ovf    = 1'b0;
    end
    flags         = '0;
    flags[PF_IDX] = ~^result;
    flags[ZF_IDX] = (result == '0);
    flags[SF_IDX] = result[W-1];
    flags[OF_IDX] = ovf;
  end

endmodule

// File: rtl/spi_exe_unit_gen.sv
// SPI-slave execution unit. One chip-select frame carries an OPW-bit
// opcode and two W-bit operands on MOSI (MSB first); the unit executes one
// ALU operation and shifts {result, PF, ZF, SF, OF} out on MISO.
//   i_sclk : SPI clock, rising edge
//   i_rst  : synchronous active-high reset
//   i_cs   : chip select, active-low
//   i_mosi : serial data in
//   o_miso : serial data out
//   o_busy : high whenever the FSM is not READY
//   o_done : one-cycle pulse after the last output bit
//   o_err  : sticky abort / illegal-opcode flag, cleared at next frame start
module spi_exe_unit_gen
  import spi_exe_pkg::*;
#(
  parameter int W   = 8,
  parameter int OPW = 4
) (
  input  logic i_sclk,
  input  logic i_rst,
  input  logic i_cs,
  input  logic i_mosi,
  output logic o_miso,
  output logic o_busy,
  output logic o_done,
  output logic o_err
);

  localparam int CW = $clog2(OPW + 3*W + 5);
  localparam int OW = W + 4;

  // Edge index of the last edge spent in each phase.
  localparam logic [CW-1:0] LAST_OP   = CW'(OPW - 1);
  localparam logic [CW-1:0] LAST_A    = CW'(OPW + W - 1);
  localparam logic [CW-1:0] LAST_B    = CW'(OPW + 2*W - 1);
  localparam logic [CW-1:0] DONE_EDGE = CW'(OPW + 3*W + 4);

  state_e         state;
  logic [CW-1:0]  cnt;
  logic [CW-1:0]  edge_idx;
  logic [OPW-1:0] op_r;
  logic [W-1:0]   a_r;
  logic [W-1:0]   b_r;
  logic [OW-1:0]  out_sr;

  logic [W-1:0]   alu_res;
  logic [3:0]     alu_flags;
  logic           alu_ill;

  alu_gen #(.W(W), .OPW(OPW)) u_alu (
    .argA    (a_r),
    .argB    (b_r),
    .oper    (op_r),
    .result  (alu_res),
    .flags   (alu_flags),
    .illegal (alu_ill)
  );

  // cnt holds the index of the previous in-frame edge.
  assign edge_idx = cnt + 1'b1;
  assign o_busy   = (state != READY);
  // MISO is the shift register MSB; clearing the register forces MISO low.
  assign o_miso   = out_sr[OW-1];

  always_ff @(posedge i_sclk) begin
    if (i_rst) begin
      state  <= READY;
      cnt    <= '0;
      op_r   <= '0;
      a_r    <= '0;
      b_r    <= '0;
      out_sr <= '0;
      o_done <= 1'b0;
      o_err  <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        READY: begin
          if (!i_cs) begin
            state <= LOAD_OP;
            cnt   <= '0;
            op_r  <= {op_r[OPW-2:0], i_mosi};
            o_err <= 1'b0;
          end
        end
        DONE: begin
          if (i_cs) state <= READY;
        end
        default: begin
          if (i_cs) begin
            state  <= READY;
            o_err  <= 1'b1;
            out_sr <= '0;
          end else begin
            cnt <= edge_idx;
            case (state)
              LOAD_OP: begin
                op_r <= {op_r[OPW-2:0], i_mosi};
                if (edge_idx == LAST_OP) state <= LOAD_A;
              end
              LOAD_A: begin
                a_r <= {a_r[W-2:0], i_mosi};
                if (edge_idx == LAST_A) state <= LOAD_B;
              end
              LOAD_B: begin
                b_r <= {b_r[W-2:0], i_mosi};
                if (edge_idx == LAST_B) state <= EXEC;
              end
              EXEC: begin
                out_sr <= {alu_res, alu_flags};
                if (alu_ill) o_err <= 1'b1;
                state  <= SHIFT_OUT;
              end
              SHIFT_OUT: begin
                if (edge_idx == DONE_EDGE) begin
                  o_done <= 1'b1;
                  out_sr <= '0;
                  state  <= DONE;
                end else begin
                  out_sr <= out_sr << 1;
                end
              end
              default: state <= READY;
            endcase
          end
        end
      endcase
    end
  end

endmodule
